// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - byte-lane data memory with registered loads and hardware clear sweep
//
// Ports:
//   clk      rising-edge clock
//   clrn     asynchronous active-low reset
//   clr      synchronous request to re-zero the array
//   req      access request, accepted when ready is high
//   we       1 = store, 0 = load
//   size     00 byte, 01 halfword, 10 word, 11 illegal
//   sext     load sign-extension select (byte/half only)
//   addr     byte address, word index addr[AW+1:2]
//   datain   right-justified store data
//   ready    high while the array is usable (RUN)
//   done     one-cycle completion pulse per accepted request
//   err      misaligned or illegal-size flag, valid with done
//   dataout  registered load result, held until the next load
module dmem_bytelane #(
  parameter int AW = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        clr,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] dataout
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t         state_q;
  logic [AW-1:0]  cnt_q;
  logic           done_q;
  logic           err_q;
  logic [31:0]    dout_q;
  logic [31:0]    mem_q [DEPTH];

  logic [AW-1:0]  idx;
  logic           accept;
  logic           bad;
  logic [31:0]    rword;
  logic [7:0]     rbyte;
  logic [15:0]    rhalf;
  logic [31:0]    load_val;
  logic [3:0]     be;
  logic [31:0]    wdata;
  logic           unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign accept      = req && (state_q == S_RUN);

  always_comb begin
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane(s) out of the stored word.
  always_comb begin
    rword    = mem_q[idx];
    rbyte    = rword[8*addr[1:0] +: 8];
    rhalf    = addr[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (size)
      2'b00:   load_val = {{24{sext & rbyte[7]}}, rbyte};
      2'b01:   load_val = {{16{sext & rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  // Store path: replicate the right-justified data into every lane and let
  // the byte enables pick which lanes actually change.
  always_comb begin
    be    = 4'b1111;
    wdata = datain;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{datain[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{datain[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = datain;
      end
    endcase
  end

  // Array has no reset: contents are defined by the sweep that follows reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (accept && we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      done_q <= accept;
      err_q  <= accept && bad;
      if (accept && !we) begin
        dout_q <= bad ? 32'h0 : load_val;
      end
      case (state_q)
        S_CLEAR: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == '1) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // An accepted request in the clr cycle still completes above.
          if (clr) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign ready   = (state_q == S_RUN);
  assign done    = done_q;
  assign err     = err_q;
  assign dataout = dout_q;

endmodule
